uart_fifo_core: RTL and testbench

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_fifo_core.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART transmitter and receiver, each with a show-ahead FIFO.
// Optional even-parity support is built when the macro UART_PARITY_EN is defined;
// without it the PARITY states, their logic and the out_Rx_PE port do not exist.
module uart_fifo_core #(
    parameter int unsigned CLK_DIV    = 10416,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_w_data,
    input  logic                 in_valid,
    output logic                 out_ready,
    output logic                 out_BUSY,
    output logic                 out_signal,
    input  logic                 in_signal,
    input  logic                 in_RXNE_clear,
    output logic [DATA_BITS-1:0] out_word,
    output logic                 out_RXNE,
    output logic                 out_Rx_ORE,
    output logic                 out_Rx_FE,
`ifdef UART_PARITY_EN
    output logic                 out_Rx_PE,
`endif
    input  logic                 in_err_clear
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1  = 16'(CLK_DIV / 2 - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW:0]          tx_wptr_q, tx_rptr_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign tx_push  = in_valid && !tx_full;
    assign tx_head  = tx_mem_q[tx_rptr_q[AW-1:0]];

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= in_w_data;
    end

    // TX FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
        end
    end

    // ---------------- TX FSM ----------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_tick, tx_line;
`ifdef UART_PARITY_EN
    logic                 tx_par_q;
`endif

    assign tx_tick = (tx_cnt_q == '0);

    // TX next state: each non-idle state lasts CLK_DIV cycles; a load pops the FIFO head
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        if (tx_state_q != StIdle && !tx_tick) tx_cnt_d = tx_cnt_q - 16'd1;
        case (tx_state_q)
            StIdle: if (!tx_empty) tx_pop = 1'b1;
            StStart: if (tx_tick) begin
                tx_state_d = StData;
                tx_cnt_d   = DIV_M1;
                tx_bit_d   = '0;
            end
            StData: if (tx_tick) begin
                tx_cnt_d = DIV_M1;
                tx_sh_d  = tx_sh_q >> 1;
                if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    tx_state_d = StParity;
`else
                    tx_state_d = StStop;
`endif
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
`ifdef UART_PARITY_EN
            StParity: if (tx_tick) begin
                tx_state_d = StStop;
                tx_cnt_d   = DIV_M1;
            end
`endif
            StStop: if (tx_tick) begin
                if (!tx_empty) tx_pop = 1'b1;  // back-to-back frame, no idle gap
                else           tx_state_d = StIdle;
            end
            default: tx_state_d = StIdle;
        endcase
        if (tx_pop) begin
            tx_state_d = StStart;
            tx_cnt_d   = DIV_M1;
            tx_sh_d    = tx_head;
        end
    end

    // TX state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

`ifdef UART_PARITY_EN
    // Even parity of the word captured when it is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tx_par_q <= 1'b0;
        else if (tx_pop) tx_par_q <= ^tx_head;
    end
`endif

    // TX line level per state
    always_comb begin
        tx_line = 1'b1;
        case (tx_state_q)
            StStart:  tx_line = 1'b0;
            StData:   tx_line = tx_sh_q[0];
`ifdef UART_PARITY_EN
            StParity: tx_line = tx_par_q;
`endif
            default:  tx_line = 1'b1;
        endcase
    end

    assign out_signal = tx_line;
    assign out_ready  = !tx_full;
    assign out_BUSY   = !tx_empty || (tx_state_q != StIdle);

    // ---------------- RX front end ----------------
    logic [1:0] rx_sync_q;
    logic       rx_prev_q, rx_s;

    assign rx_s = rx_sync_q[1];

    // Two-flop synchroniser plus previous value for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], in_signal};
            rx_prev_q <= rx_s;
        end
    end

    // ---------------- RX FSM ----------------
    logic [2:0]           rx_state_q, rx_state_d;
    logic [15:0]          rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_tick, rx_push, fe_set, pe_set;

    assign rx_tick = (rx_cnt_q == '0);

    // RX next state: first sample half a bit after the start edge, then every bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        pe_set     = 1'b0;
        if (rx_state_q != StIdle && !rx_tick) rx_cnt_d = rx_cnt_q - 16'd1;
        case (rx_state_q)
            StIdle: if (rx_prev_q && !rx_s) begin
                rx_state_d = StStart;
                rx_cnt_d   = HALF_M1;
            end
            StStart: if (rx_tick) begin
                if (rx_s) begin
                    rx_state_d = StIdle;  // glitch
                end else begin
                    rx_state_d = StData;
                    rx_cnt_d   = DIV_M1;
                    rx_bit_d   = '0;
                end
            end
            StData: if (rx_tick) begin
                rx_cnt_d = DIV_M1;
                rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                    rx_state_d = StParity;
`else
                    rx_state_d = StStop;
`endif
                end else begin
                    rx_bit_d = rx_bit_q + 3'd1;
                end
            end
`ifdef UART_PARITY_EN
            StParity: if (rx_tick) begin
                if (rx_s != ^rx_sh_q) begin
                    pe_set     = 1'b1;
                    rx_state_d = StIdle;
                end else begin
                    rx_state_d = StStop;
                    rx_cnt_d   = DIV_M1;
                end
            end
`endif
            StStop: if (rx_tick) begin
                rx_state_d = StIdle;
                if (rx_s) rx_push = 1'b1;
                else      fe_set  = 1'b1;
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // RX state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW:0]          rx_wptr_q, rx_rptr_q;
    logic                 rx_empty, rx_full, rx_pop, rx_wr, ore_set;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_pop   = in_RXNE_clear && !rx_empty;
    // A simultaneous pop frees the slot, so a push to a full FIFO still lands
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign ore_set  = rx_push && rx_full && !rx_pop;

    // RX FIFO storage write
    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_sh_q;
    end

    // RX FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (rx_wr)  rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop) rx_rptr_q <= rx_rptr_q + PTR_ONE;
        end
    end

    assign out_word = rx_mem_q[rx_rptr_q[AW-1:0]];
    assign out_RXNE = !rx_empty;

    // Sticky error flags: a set in the same cycle as a clear wins
    logic ore_q, fe_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ore_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            if (ore_set)           ore_q <= 1'b1;
            else if (in_err_clear) ore_q <= 1'b0;
            if (fe_set)            fe_q  <= 1'b1;
            else if (in_err_clear) fe_q  <= 1'b0;
        end
    end

    assign out_Rx_ORE = ore_q;
    assign out_Rx_FE  = fe_q;

`ifdef UART_PARITY_EN
    logic pe_q;
    // Sticky parity-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               pe_q <= 1'b0;
        else if (pe_set)       pe_q <= 1'b1;
        else if (in_err_clear) pe_q <= 1'b0;
    end
    assign out_Rx_PE = pe_q;
`else
    logic unused_pe;
    assign unused_pe = pe_set;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core (default build, no parity).
module tb_uart_fifo_core;

    localparam int DIV   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_w_data = '0;
    logic       in_valid = 1'b0;
    logic       in_RXNE_clear = 1'b0;
    logic       in_err_clear = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       in_signal;
    logic       out_ready, out_BUSY, out_signal, out_RXNE, out_Rx_ORE, out_Rx_FE;
    logic [7:0] out_word;

    assign in_signal = loop_en ? out_signal : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(
        .CLK_DIV   (DIV),
        .DATA_BITS (8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_w_data    (in_w_data),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .out_BUSY     (out_BUSY),
        .out_signal   (out_signal),
        .in_signal    (in_signal),
        .in_RXNE_clear(in_RXNE_clear),
        .out_word     (out_word),
        .out_RXNE     (out_RXNE),
        .out_Rx_ORE   (out_Rx_ORE),
        .out_Rx_FE    (out_Rx_FE),
        .in_err_clear (in_err_clear)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Behavioural model: TX queue + frame timer, RX queue + sticky flags
    logic [7:0] tq[$];
    logic [7:0] rxq[$];
    bit         act = 1'b0;
    int         t = 0;
    logic [7:0] cur = '0;
    bit         m_ore = 1'b0;
    bit         m_fe = 1'b0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void rx_push(logic [7:0] d);
        if (rxq.size() < DEPTH) rxq.push_back(d);
        else m_ore = 1'b1;
    endfunction

    // Expected TX line: frame bit index = elapsed cycles / DIV
    function automatic logic exp_line();
        int b;
        if (!act) return 1'b1;
        b = t / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int pre;
        if (rst) begin
            tq.delete();
            rxq.delete();
            act = 1'b0;
            t = 0;
            m_ore = 1'b0;
            m_fe = 1'b0;
        end else begin
            pre = tq.size();
            if (act) begin
                if (t == FRAME - 1) begin
                    if (loop_en) rx_push(cur);
                    if (pre > 0) begin
                        cur = tq.pop_front();
                        t = 0;
                    end else begin
                        act = 1'b0;
                    end
                end else begin
                    t++;
                end
            end else if (pre > 0) begin
                cur = tq.pop_front();
                act = 1'b1;
                t = 0;
            end
            if (in_valid && pre < DEPTH) tq.push_back(in_w_data);
        end
    end

    // Per-cycle TX comparison, away from the active edge
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("tx_line", 32'(out_signal), 32'(exp_line()));
            chk("tx_ready", 32'(out_ready), 32'(tq.size() < DEPTH));
            chk("tx_busy", 32'(out_BUSY), 32'(tq.size() > 0 || act));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_w_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        in_RXNE_clear = 1'b1;
        tick();
        in_RXNE_clear = 1'b0;
        if (rxq.size() > 0) void'(rxq.pop_front());
    endtask

    task automatic err_clear();
        in_err_clear = 1'b1;
        tick();
        in_err_clear = 1'b0;
        m_ore = 1'b0;
        m_fe = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((act || tq.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(n >= bound), 32'd0);
        repeat (20) tick();
    endtask

    task automatic check_rx(input string name);
        chk({name, "_rxne"}, 32'(out_RXNE), 32'(rxq.size() > 0));
        if (rxq.size() > 0) chk({name, "_word"}, 32'(out_word), 32'(rxq[0]));
        chk({name, "_ore"}, 32'(out_Rx_ORE), 32'(m_ore));
        chk({name, "_fe"}, 32'(out_Rx_FE), 32'(m_fe));
    endtask

    task automatic drain(input string name);
        while (rxq.size() > 0) begin
            chk({name, "_word"}, 32'(out_word), 32'(rxq[0]));
            pop1();
        end
        chk({name, "_empty"}, 32'(out_RXNE), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_drv = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (DIV) tick();
        end
        rx_drv = stop;
        repeat (DIV) tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        if (stop) rx_push(d);
        else m_fe = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_bits [10];
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_line", 32'(out_signal), 32'd1);
        chk("rst_ready", 32'(out_ready), 32'd1);
        chk("rst_busy", 32'(out_BUSY), 32'd0);
        chk("rst_rxne", 32'(out_RXNE), 32'd0);
        chk("rst_ore", 32'(out_Rx_ORE), 32'd0);
        chk("rst_fe", 32'(out_Rx_FE), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) tick();

        // Single 0xA5 frame, bit levels pinned at mid-bit, looped back to RX
        loop_en = 1'b1;
        write_byte(8'hA5);
        @(negedge clk);
        chk("a5_pre_line", 32'(out_signal), 32'd1);
        chk("a5_pre_busy", 32'(out_BUSY), 32'd1);
        for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? 9 : 16) @(negedge clk);
            chk("a5_bit", 32'(out_signal), 32'(exp_bits[b]));
        end
        repeat (7) @(negedge clk);
        chk("a5_busy_last_stop", 32'(out_BUSY), 32'd1);
        @(negedge clk);
        chk("a5_busy_after", 32'(out_BUSY), 32'd0);
        @(posedge clk);
        #1;
        wait_idle("a5", 1000);
        chk("a5_rx_word", 32'(out_word), 32'h A5);
        check_rx("a5");
        drain("a5");

        // Three consecutive writes -> back-to-back frames
        in_valid = 1'b1;
        in_w_data = 8'h01;
        tick();
        in_w_data = 8'h02;
        tick();
        in_w_data = 8'h03;
        tick();
        in_valid = 1'b0;
        repeat (159) @(negedge clk);
        chk("b2b_stop1", 32'(out_signal), 32'd1);
        @(negedge clk);
        chk("b2b_start2", 32'(out_signal), 32'd0);
        repeat (159) @(negedge clk);
        chk("b2b_stop2", 32'(out_signal), 32'd1);
        @(negedge clk);
        chk("b2b_start3", 32'(out_signal), 32'd0);
        repeat (159) @(negedge clk);
        chk("b2b_busy_last", 32'(out_BUSY), 32'd1);
        @(negedge clk);
        chk("b2b_busy_done", 32'(out_BUSY), 32'd0);
        @(posedge clk);
        #1;
        wait_idle("b2b", 1000);
        chk("b2b_first", 32'(out_word), 32'h01);
        check_rx("b2b");
        drain("b2b");

        // Randomized writes, FIFO regularly full, looped back
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_w_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_idle("rand", 20000);
        check_rx("rand");
        drain("rand");
        err_clear();
        check_rx("rand_clr");

        // 17 bytes into a 16-deep RX FIFO without pops -> overrun
        for (int i = 0; i < 17; i++) write_byte(8'(i * 7 + 3));
        wait_idle("ovr", 5000);
        chk("ovr_flag", 32'(out_Rx_ORE), 32'd1);
        chk("ovr_head", 32'(out_word), 32'h03);
        check_rx("ovr");
        drain("ovr");
        err_clear();
        chk("ovr_cleared", 32'(out_Rx_ORE), 32'd0);
        loop_en = 1'b0;

        // Short low glitch -> nothing received
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        chk("glitch_rxne", 32'(out_RXNE), 32'd0);
        chk("glitch_fe", 32'(out_Rx_FE), 32'd0);
        chk("glitch_ore", 32'(out_Rx_ORE), 32'd0);

        // Framing error on 0x3C
        send_frame(8'h3C, 1'b0);
        chk("fe_flag", 32'(out_Rx_FE), 32'd1);
        chk("fe_rxne", 32'(out_RXNE), 32'd0);
        check_rx("fe");
        pop1();
        chk("pop_empty", 32'(out_RXNE), 32'd0);
        err_clear();
        chk("fe_cleared", 32'(out_Rx_FE), 32'd0);

        // Reset during TX data bit 3, then receive 0x55
        write_byte(8'hF0);
        begin
            int n = 0;
            while (!(act && t == 4 * DIV + 8) && n < 300) begin
                tick();
                n++;
            end
            chk("rst_mid_timeout", 32'(n >= 300), 32'd0);
        end
        chk("mid_bit3", 32'(out_signal), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_line", 32'(out_signal), 32'd1);
        chk("mid_rst_busy", 32'(out_BUSY), 32'd0);
        chk("mid_rst_ready", 32'(out_ready), 32'd1);
        chk("mid_rst_rxne", 32'(out_RXNE), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        send_frame(8'h55, 1'b1);
        chk("post_rst_word", 32'(out_word), 32'h55);
        check_rx("post_rst");
        drain("post_rst");

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
